eq_cmp_bist: RTL and testbench

EQ_CMP_BIST -- requirements
Module: eq_cmp_bist

---
 rtl/eq_cmp_bist_pkg.sv | 21 ++
 rtl/eq_golden.sv | 20 ++
 rtl/eq_cmp_bist.sv | 167 ++++++++++++++++
 tb/tb_eq_cmp_bist.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eq_cmp_bist_pkg.sv
// -----------------------------------------------------------------------------
// eq_cmp_bist_pkg
// Shared definitions for the equality-comparator BIST block:
//   - state_t          : FSM state encoding (IDLE / DRIVE / SAMPLE / DONE)
//   - DEFAULT_WIDTH    : default operand width of the comparator under test
//   - DEFAULT_SETTLE   : default number of cycles each vector is driven
//                        before its response is sampled
// -----------------------------------------------------------------------------
package eq_cmp_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_SETTLE = 1;

endpackage : eq_cmp_bist_pkg

// File: rtl/eq_golden.sv
// -----------------------------------------------------------------------------
// eq_golden
// Combinational reference equality function used by the BIST to compute the
// response the comparator under test is expected to give.
// Ports:
//   a [WIDTH-1:0] : operand A
//   b [WIDTH-1:0] : operand B
//   c             : 1 when a == b
// -----------------------------------------------------------------------------
module eq_golden #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c
);

    assign c = (a == b);

endmodule : eq_golden

// File: rtl/eq_cmp_bist.sv
// -----------------------------------------------------------------------------
// eq_cmp_bist
// Exhaustive built-in self test for an external WIDTH-bit equality comparator.
// Every (A,B) pair is driven in order A=0,B=0 .. A=max,B=max. Each vector is
// held SETTLE cycles (DRIVE) plus one cycle (SAMPLE); at the edge ending SAMPLE
// the comparator response c_in is checked against the golden model.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a run (honoured in IDLE or DONE only)
//   a_out, b_out          : operands driven to the comparator under test
//   c_in                  : equality response from the comparator under test
//   busy                  : run in progress (DRIVE / SAMPLE)
//   done                  : run complete (DONE), held until start or rst
//   pass                  : in DONE, high iff no mismatches were seen
//   err_count             : number of mismatching vectors
//   fail_valid            : a mismatch has been captured this run
//   fail_a, fail_b        : operands of the first mismatching vector
// -----------------------------------------------------------------------------
module eq_cmp_bist
    import eq_cmp_bist_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int IDX_W = 2 * WIDTH;
    localparam int ERR_W = 2 * WIDTH + 1;
    // Settle counter only needs to reach SETTLE-1; keep at least one bit.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = '1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_valid_q, fail_valid_d;
    logic [WIDTH-1:0]   fail_a_q, fail_a_d;
    logic [WIDTH-1:0]   fail_b_q, fail_b_d;

    logic               exp_c;
    logic               launch;
    logic               mismatch;

    // Operands come straight from the vector index: A is the upper half so
    // B sweeps fastest.
    assign a_out = idx_q[IDX_W-1:WIDTH];
    assign b_out = idx_q[WIDTH-1:0];

    eq_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a (a_out),
        .b (b_out),
        .c (exp_c)
    );

    assign launch   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign mismatch = (c_in != exp_c);

    // ------------------------------------------------------------------
    // State register (and datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_DRIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: vector index, settle counter, result capture
    // ------------------------------------------------------------------
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;

        if (launch) begin
            idx_d        = '0;
            cnt_d        = '0;
            err_d        = '0;
            fail_valid_d = 1'b0;
            fail_a_d     = '0;
            fail_b_d     = '0;
        end else if (state_q == ST_DRIVE) begin
            cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
        end else if (state_q == ST_SAMPLE) begin
            if (mismatch) begin
                err_d = err_q + 1'b1;
                // Only the first mismatching vector of a run is recorded.
                if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_a_d     = a_out;
                    fail_b_d     = b_out;
                end
            end
            // The last index is held in DONE so the operands stay stable.
            if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (err_q == '0);
    end

    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule : eq_cmp_bist

// File: tb/tb_eq_cmp_bist.sv
// -----------------------------------------------------------------------------
// tb_eq_cmp_bist
// Scoreboard bench for eq_cmp_bist with default parameters. Each run pushes its
// expected outcome into a queue; an independent monitor pops and compares when
// done rises. c_in is produced by a behavioural comparator model that can be
// correct, stuck, inverted, or faulty on a random set of vectors.
// -----------------------------------------------------------------------------
module tb_eq_cmp_bist;

    localparam int W       = 4;
    localparam int NV      = 1 << (2 * W);
    localparam int RUN_LEN = NV * 2;   // (SETTLE + 1) cycles per vector
    localparam int MAXV    = (1 << W) - 1;

    typedef struct {
        int err;
        bit fv;
        int fa;
        int fb;
        bit pass;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_out, b_out;
    logic           c_in;
    logic           busy, done, pass;
    logic [2*W:0]   err_count;
    logic           fail_valid;
    logic [W-1:0]   fail_a, fail_b;

    int   mode;
    bit   fault_mask [NV];
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done_prev = 1'b0;
    exp_t sb_q[$];
    exp_t last_exp;

    eq_cmp_bist dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_out      (a_out),
        .b_out      (b_out),
        .c_in       (c_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_a     (fail_a),
        .fail_b     (fail_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator under test (behavioural)
    always_comb begin
        c_in = 1'b0;
        case (mode)
            0: c_in = (a_out == b_out);
            1: c_in = 1'b0;
            2: c_in = 1'b1;
            3: c_in = (a_out != b_out);
            default: c_in = (a_out == b_out) ^ fault_mask[{a_out, b_out}];
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sweep every operand pair, compare the random-fault
    // comparator's answer with true equality.
    function automatic exp_t model_random();
        exp_t e;
        e.err = 0; e.fv = 0; e.fa = 0; e.fb = 0;
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                bit truth = (a == b);
                bit resp  = truth ^ fault_mask[a * (MAXV + 1) + b];
                if (resp != truth) begin
                    if (!e.fv) begin
                        e.fv = 1; e.fa = a; e.fb = b;
                    end
                    e.err++;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    function automatic exp_t mk(int err, bit fv, int fa, int fb);
        exp_t e;
        e.err = err; e.fv = fv; e.fa = fa; e.fb = fb; e.pass = (err == 0);
        return e;
    endfunction

    // Monitor: pops one expectation per rising done
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("latency", cyc - start_cyc, RUN_LEN);
                check("err_count", err_count, e.err);
                check("pass", pass, e.pass);
                check("fail_valid", fail_valid, e.fv);
                check("fail_a", fail_a, e.fa);
                check("fail_b", fail_b, e.fb);
                $display("run done: mode=%0d err=%0d pass=%0d fail=(%0d,%0d) latency=%0d",
                         mode, err_count, pass, fail_a, fail_b, cyc - start_cyc);
            end
        end
        done_prev = done;
    end

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("launch_busy", busy, 1);
        check("launch_done", done, 0);
        check("launch_err_clr", err_count, 0);
        check("launch_fv_clr", fail_valid, 0);
    endtask

    task automatic do_run(input int m, input exp_t e, input bit repulse);
        int k;
        mode = m;
        last_exp = e;
        sb_q.push_back(e);
        launch();
        k = 0;
        while (!done && k < RUN_LEN + 100) begin
            @(negedge clk);
            start = (repulse && (cyc == start_cyc + 50));
            k++;
        end
        start = 1'b0;
        check("done_timeout", done, 1);
        repeat (3) @(negedge clk);
        check("hold_a", a_out, MAXV);
        check("hold_b", b_out, MAXV);
        check("hold_done", done, 1);
        check("hold_busy", busy, 0);
        check("hold_err", err_count, last_exp.err);
        check("hold_pass", pass, last_exp.pass);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, a_out, 0);
        check({tag, "_b"}, b_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_fv"}, fail_valid, 0);
        check({tag, "_fa"}, fail_a, 0);
        check({tag, "_fb"}, fail_b, 0);
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        foreach (fault_mask[i]) fault_mask[i] = 1'b0;

        // Reset, with start asserted to confirm reset wins
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed runs (expected results are fixed by the comparator behaviour)
        do_run(0, mk(0, 0, 0, 0), 1'b0);
        do_run(1, mk(16, 1, 0, 0), 1'b0);     // start from DONE
        do_run(2, mk(240, 1, 0, 1), 1'b0);
        do_run(3, mk(256, 1, 0, 0), 1'b1);    // start re-pulsed mid-run

        // Reset mid-run at vector index 100
        mode = 1;
        launch();
        k = 0;
        while ({a_out, b_out} != 8'd100 && k < RUN_LEN) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx100", {a_out, b_out}, 100);
        check("midrun_err", err_count, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_idle", busy, 0);
        $display("mid-run reset applied at index 100");

        do_run(0, mk(0, 0, 0, 0), 1'b0);

        // Random fault patterns checked against the sweep model
        for (int r = 0; r < 3; r++) begin
            foreach (fault_mask[i]) fault_mask[i] = ($urandom_range(0, 7) == 0);
            do_run(4, model_random(), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_eq_cmp_bist
